// File: rtl/ff_bank_pkg.sv
// Shared definitions for the ff_bank register block: operation encodings
// and the mode type carried on the bank's control interface.
package ff_bank_pkg;

  typedef enum logic [2:0] {
    MODE_HOLD   = 3'd0,
    MODE_LOAD   = 3'd1,
    MODE_TOGGLE = 3'd2,
    MODE_SHL    = 3'd3,
    MODE_SHR    = 3'd4,
    MODE_UP     = 3'd5,
    MODE_DOWN   = 3'd6,
    MODE_CLEAR  = 3'd7
  } mode_e;

  localparam int unsigned MODE_W = 3;

endpackage : ff_bank_pkg

// File: rtl/ff_bank_if.sv
// Control/data bundle between a driver and ff_bank. The master drives the
// operation request; the slave (the bank) returns register state.
interface ff_bank_if
  import ff_bank_pkg::*;
#(
  parameter int unsigned WIDTH = 4
);

  logic             enable;
  mode_e            mode;
  logic [WIDTH-1:0] d;
  logic             ser_in;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_n;
  logic             ser_out;
  logic             carry;

  modport master (
    output enable, mode, d, ser_in,
    input  q, q_n, ser_out, carry
  );

  modport slave (
    input  enable, mode, d, ser_in,
    output q, q_n, ser_out, carry
  );

endinterface : ff_bank_if

// File: rtl/ff_cell.sv
// Single flip-flop bit with clock enable and asynchronous active-high reset
// to a parametrised value.
module ff_cell #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic en_i,
  input  logic d_i,
  output logic q_o
);

  logic bit_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bit_q <= RST_VAL;
    end else if (en_i) begin
      bit_q <= d_i;
    end
  end

  assign q_o = bit_q;

endmodule : ff_cell

// File: rtl/ff_bank.sv
// WIDTH-bit multi-mode register bank: hold, load, toggle, shift, count and
// clear, built from ff_cell bits fed by a single next-state mux.
module ff_bank
  import ff_bank_pkg::*;
#(
  parameter int unsigned      WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic        clk,
  input  logic        reset,
  ff_bank_if.slave    bus
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;
  logic             ser_q;
  logic             ser_d;
  logic             ser_en;
  logic             carry_q;
  logic             carry_d;

  always_comb begin
    q_d     = q_q;
    ser_d   = ser_q;
    ser_en  = 1'b0;
    carry_d = 1'b0;
    unique case (bus.mode)
      MODE_HOLD:   q_d = q_q;
      MODE_LOAD:   q_d = bus.d;
      MODE_TOGGLE: q_d = q_q ^ bus.d;
      MODE_SHL: begin
        q_d    = {q_q[WIDTH-2:0], bus.ser_in};
        ser_d  = q_q[WIDTH-1];
        ser_en = 1'b1;
      end
      MODE_SHR: begin
        q_d    = {bus.ser_in, q_q[WIDTH-1:1]};
        ser_d  = q_q[0];
        ser_en = 1'b1;
      end
      MODE_UP: begin
        q_d     = q_q + WIDTH'(1);
        carry_d = (q_q == '1);
      end
      MODE_DOWN: begin
        q_d     = q_q - WIDTH'(1);
        carry_d = (q_q == '0);
      end
      MODE_CLEAR:  q_d = RESET_VALUE;
      default:     q_d = q_q;
    endcase
    // carry is a one-shot flag: a disabled edge always clears it
    if (!bus.enable) begin
      carry_d = 1'b0;
    end
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    ff_cell #(.RST_VAL(RESET_VALUE[i])) u_cell (
      .clk   (clk),
      .reset (reset),
      .en_i  (bus.enable),
      .d_i   (q_d[i]),
      .q_o   (q_q[i])
    );
  end

  ff_cell #(.RST_VAL(1'b0)) u_ser_out (
    .clk   (clk),
    .reset (reset),
    .en_i  (bus.enable & ser_en),
    .d_i   (ser_d),
    .q_o   (ser_q)
  );

  // enable tied high so the flag is rewritten (normally to 0) every edge
  ff_cell #(.RST_VAL(1'b0)) u_carry (
    .clk   (clk),
    .reset (reset),
    .en_i  (1'b1),
    .d_i   (carry_d),
    .q_o   (carry_q)
  );

  assign bus.q       = q_q;
  assign bus.q_n     = ~q_q;
  assign bus.ser_out = ser_q;
  assign bus.carry   = carry_q;

endmodule : ff_bank

// File: doc/ff_bank.md
# ff_bank

Parametrised multi-mode register bank: the successor to the single-bit D/T flip-flop pair in the Laboratorio 9 flip-flop exercises. It holds WIDTH flip-flop bits with a shared clock enable and asynchronous reset. Each enabled clock applies one of eight operations: hold, parallel load, masked toggle, shift left/right, count up/down, or synchronous clear. It is the general register building block for the counter and shift-register labs that follow.

## Interface

- WIDTH, default 4: number of flip-flop bits, legal range 2..32.
- RESET_VALUE, default 0: value of q while reset is high; WIDTH bits.
- clk  input  1  rising-edge clock.
- reset  input  1  reset, asynchronous, active-high.
- enable  input  1  clock enable; 0 forces hold regardless of mode.
- mode  input  3  operation select, encodings below.
- d  input  WIDTH  load data (LOAD) or toggle mask (TOGGLE); ignored otherwise.
- ser_in  input  1  serial input for shift modes.
- q  output  WIDTH  register contents.
- q_n  output  WIDTH  combinational bitwise complement of q.
- ser_out  output  1  registered bit shifted out by the most recent shift.
- carry  output  1  registered one-cycle wrap flag for count modes.

## Operation

Mode encodings:
- 0 HOLD: q unchanged.
- 1 LOAD: q <= d.
- 2 TOGGLE: q <= q ^ d, so bits with d=1 invert (T flip-flop behaviour per bit).
- 3 SHL: q <= {q[WIDTH-2:0], ser_in}; ser_out <= q[WIDTH-1].
- 4 SHR: q <= {ser_in, q[WIDTH-1:1]}; ser_out <= q[0].
- 5 UP: q <= q + 1, modulo 2^WIDTH.
- 6 DOWN: q <= q - 1, modulo 2^WIDTH.
- 7 CLEAR: q <= RESET_VALUE, synchronous.

Rules:
- enable=0: q and ser_out hold; carry <= 0.
- ser_out changes only in SHL or SHR. All other modes hold it.
- carry <= 1 only when UP is applied with q = all ones, or DOWN is applied with q = 0. Otherwise carry <= 0 on every edge, so it is never held high for two cycles unless the wrap repeats.
- Arithmetic is unsigned WIDTH-bit. There is no saturation.
- No X propagation is allowed: every mode value is defined.

## Timing

- Reset: the output values below apply immediately on reset rising, with no clock required, and hold while reset is high:
  - q = RESET_VALUE
  - q_n = ~RESET_VALUE
  - ser_out = 0
  - carry = 0
- The first rising clk edge after reset falls applies the current mode.
- Latency: one clock from mode/d/ser_in sampled to q, ser_out and carry valid. q_n follows q combinationally, in the same cycle.
- Reset asserted mid-operation overrides any mode in the same instant. The count/shift in progress is discarded.
- Reset rising coincident with a clk edge: reset wins.
- Inputs are sampled only at the rising clk edge. Changes between edges have no effect on state.

## Structure

- Package ff_bank_pkg holds:
  - the mode encodings as named 3-bit constants: MODE_HOLD .. MODE_CLEAR;
  - a mode typedef.
- Sub-module ff_cell: one bit with D input, enable and asynchronous active-high reset, parametrised by reset bit value. The bank instantiates WIDTH of these.
- Next-state logic is a single combinational mux on mode in ff_bank, feeding the cells' D inputs.
- ser_out and carry are two additional ff_cell instances.
- q_n is a plain assign.

## Test plan

WIDTH=4, RESET_VALUE=4'b0101 unless noted.
- Reset: pulse reset high between clock edges -> q=0101, q_n=1010, carry=0, ser_out=0 immediately with no clk edge. Hold enable=1, mode=LOAD, d=1111 during reset -> q stays 0101.
- Load and toggle: LOAD d=1100, then TOGGLE d=1010 -> q=1100, then q=0110. Next cycle enable=0 with mode=TOGGLE -> q stays 0110.
- Shifts: from q=1001, SHL ser_in=0 -> q=0010, ser_out=1. Then SHR ser_in=1 -> q=1001, ser_out=0.
- Up wrap: LOAD 1110, then UP x3 -> q=1111, 0000, 0001. carry=1 only in the cycle q=0000.
- Down wrap: LOAD 0001, then DOWN x2 -> q=0000, 1111. carry=1 only in the cycle q=1111.
- Clear and async reset mid-count: UP running from 0011, CLEAR -> q=0101. Resume UP, assert reset between edges -> q=0101 instantly. After release, first edge gives q=0110.
